dly_sched: RTL

Cycle-accurate scheduler for delayed register updates. It emulates intra-assignment delayed nonblocking writes (`q <= #D v`) in synthesizable form. The upstream logic issues (value, delay) requests; the block holds them in a small slot array and applies each one to a single output register after exactly D+1 clocks. It sits directly upstream of the consumer register and drives out_data/out_upd into it.

---
 rtl/dly_sched.sv | 107 ++++++++++
 1 files changed

// File: rtl/dly_sched.sv
// Cycle-accurate scheduler for delayed register updates: each accepted (value, delay D)
// request is applied to out_data exactly D+1 clocks after acceptance, last-write-wins on ties.
module dly_sched #(
    parameter int               WIDTH     = 32,
    parameter int               DEPTH     = 4,
    parameter int               DLYW      = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [WIDTH-1:0]               in_data,
    input  logic [DLYW-1:0]                in_dly,
    input  logic                           flush,
    output logic [WIDTH-1:0]               out_data,
    output logic                           out_upd,
    output logic [$clog2(DEPTH+1)-1:0]     pending
);

    localparam int              PW   = $clog2(DEPTH + 1);
    localparam logic [PW-1:0]   FULL = PW'(DEPTH);

    logic [DEPTH-1:0] valid;
    logic [WIDTH-1:0] data [DEPTH];
    logic [DLYW-1:0]  rem  [DEPTH];
    logic [DLYW-1:0]  orig [DEPTH];

    logic [DEPTH-1:0] retire;
    logic [DEPTH-1:0] free_oh;
    logic             any_ret;
    logic [WIDTH-1:0] win_data;
    logic [DLYW-1:0]  win_orig;
    logic             accept;

    // Retirement scan: the co-expiring slot with the smallest original delay was issued last.
    // NOTE: every signal driven here gets a default before any condition, so no latch is inferred.
    always_comb begin
        retire   = '0;
        any_ret  = 1'b0;
        win_data = '0;
        win_orig = '1;
        for (int i = 0; i < DEPTH; i++) begin
            retire[i] = valid[i] && (rem[i] == '0);
            if (retire[i] && (!any_ret || orig[i] < win_orig)) begin
                win_orig = orig[i];
                win_data = data[i];
            end
            if (retire[i])
                any_ret = 1'b1;
        end
    end

    always_comb begin
        free_oh = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!valid[i] && (free_oh == '0))
                free_oh[i] = 1'b1;
        end
    end

    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++)
            pending = pending + PW'(valid[i]);
    end

    assign in_ready = (pending < FULL) && !flush;
    assign accept   = in_valid && in_ready;

    // NOTE: state registers use non-blocking assignments so every slot samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid    <= '0;
            out_data <= RESET_VAL;
            out_upd  <= 1'b0;
        end else begin
            out_upd <= any_ret && !flush;
            if (any_ret && !flush)
                out_data <= win_data;
            if (flush) begin
                valid <= '0;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (retire[i])
                        valid[i] <= 1'b0;
                    else if (accept && free_oh[i])
                        valid[i] <= 1'b1;
                end
            end
        end
    end

    // NOTE: slot payload is qualified by valid, so it carries no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (accept && free_oh[i]) begin
                data[i] <= in_data;
                rem[i]  <= in_dly;
                orig[i] <= in_dly;
            end else if (valid[i] && (rem[i] != '0)) begin
                rem[i] <= rem[i] - 1'b1;
            end
        end
    end

endmodule
